// File: rtl/inv_mix_col_unit_pkg.sv
// Shared definitions for the inverse-MixColumns decryption stage.
//   - GF(2^8) reduction constant and InvMixColumns coefficients
//   - byte / column / FSM state typedefs
//   - xtime and constant-multiply helpers (coefficients are at most 4 bits)
package inv_mix_col_unit_pkg;

  typedef logic [7:0]      byte_t;
  typedef logic [3:0][7:0] col_t;   // element 0 is row 0 (first byte of a column)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } st_e;

  localparam byte_t GF_RED = 8'h1B;  // x^8 = x^4 + x^3 + x + 1
  localparam byte_t C09    = 8'h09;
  localparam byte_t C0B    = 8'h0B;
  localparam byte_t C0D    = 8'h0D;
  localparam byte_t C0E    = 8'h0E;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  // Multiply by a constant whose value fits in 4 bits: sum of a, 2a, 4a, 8a.
  function automatic byte_t gf_mul_c(input byte_t a, input logic [3:0] c);
    byte_t acc;
    byte_t p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_col_unit_if.sv
// Stream bus of the inverse-MixColumns stage.
//   run     : one-cycle start pulse (clears stream state)
//   running : stream-advance enable
//   in0     : state byte in [7:0]
//   in1     : round-key byte in [7:0]
//   in2     : bit 0 = bypass mixing (only with INV_MIX_COL_BYPASS_EN)
//   out0    : result byte in [7:0], upper bits zero
// master drives the stream, slave is the stage.
interface inv_mix_col_unit_if #(
  parameter int DATA_W = 32
);
  logic              run;
  logic              running;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
`ifdef INV_MIX_COL_BYPASS_EN
  logic [DATA_W-1:0] in2;
`endif
  logic [DATA_W-1:0] out0;

`ifdef INV_MIX_COL_BYPASS_EN
  modport master (output run, running, in0, in1, in2, input out0);
  modport slave  (input run, running, in0, in1, in2, output out0);
`else
  modport master (output run, running, in0, in1, input out0);
  modport slave  (input run, running, in0, in1, output out0);
`endif
endinterface

// File: rtl/inv_mix_col_unit_mix.sv
// inv_mix_column: combinational InvMixColumns of one 4-byte column.
//   col_i : a0..a3 (element 0 = a0)
//   col_o : b0..b3 (element 0 = b0)
module inv_mix_column
  import inv_mix_col_unit_pkg::*;
(
  input  col_t col_i,
  output col_t col_o
);

  always_comb begin
    col_o[0] = gf_mul_c(col_i[0], C0E[3:0]) ^ gf_mul_c(col_i[1], C0B[3:0]) ^
               gf_mul_c(col_i[2], C0D[3:0]) ^ gf_mul_c(col_i[3], C09[3:0]);
    col_o[1] = gf_mul_c(col_i[0], C09[3:0]) ^ gf_mul_c(col_i[1], C0E[3:0]) ^
               gf_mul_c(col_i[2], C0B[3:0]) ^ gf_mul_c(col_i[3], C0D[3:0]);
    col_o[2] = gf_mul_c(col_i[0], C0D[3:0]) ^ gf_mul_c(col_i[1], C09[3:0]) ^
               gf_mul_c(col_i[2], C0E[3:0]) ^ gf_mul_c(col_i[3], C0B[3:0]);
    col_o[3] = gf_mul_c(col_i[0], C0B[3:0]) ^ gf_mul_c(col_i[1], C0D[3:0]) ^
               gf_mul_c(col_i[2], C09[3:0]) ^ gf_mul_c(col_i[3], C0E[3:0]);
  end

endmodule

// File: rtl/inv_mix_col_unit.sv
// inv_mix_col_unit: byte-serial AddRoundKey + InvMixColumns stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : inv_mix_col_unit_if.slave (run, running, in0, in1, [in2], out0)
// Bytes (in0 ^ in1) are gathered into col_buf; the fourth byte of a column
// completes it, the column is transformed and loaded into out_sr, which then
// shifts one byte per advancing cycle onto out0. Fixed latency of 4 cycles.
// Optional feature macro: INV_MIX_COL_BYPASS_EN (per-column mixing bypass).
module inv_mix_col_unit
  import inv_mix_col_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  inv_mix_col_unit_if.slave  bus
);

  st_e        state;
  logic [1:0] cnt;
  byte_t      col_buf [3];
  col_t       out_sr;
  col_t       col_in;
  col_t       col_mix;
  col_t       col_ld;
  byte_t      byte_in;
  logic       adv;
  logic       last_row;

  assign adv      = bus.running & ~bus.run;
  assign byte_in  = bus.in0[7:0] ^ bus.in1[7:0];
  assign last_row = (cnt == 2'd3);
  assign col_in   = {byte_in, col_buf[2], col_buf[1], col_buf[0]};

  inv_mix_column u_mix (
    .col_i (col_in),
    .col_o (col_mix)
  );

`ifdef INV_MIX_COL_BYPASS_EN
  logic byp;
  logic unused_in2;
  assign unused_in2 = ^bus.in2[DATA_W-1:1];
  assign col_ld     = byp ? col_in : col_mix;
`else
  assign col_ld = col_mix;
`endif

  logic unused_hi;
  assign unused_hi = ^{bus.in0[DATA_W-1:8], bus.in1[DATA_W-1:8]};

  assign bus.out0 = {{(DATA_W-8){1'b0}}, out_sr[0]};

  // Stage: column gather -> output shift register
  always_ff @(posedge clk) begin
    if (rst || bus.run) begin
      cnt        <= 2'd0;
      col_buf[0] <= 8'h00;
      col_buf[1] <= 8'h00;
      col_buf[2] <= 8'h00;
      out_sr     <= '0;
      state      <= ST_IDLE;
`ifdef INV_MIX_COL_BYPASS_EN
      if (rst) byp <= 1'b0;
`endif
    end else if (adv) begin
      cnt <= cnt + 2'd1;
      if (!last_row) col_buf[cnt] <= byte_in;
`ifdef INV_MIX_COL_BYPASS_EN
      if (cnt == 2'd0) byp <= bus.in2[0];
`endif
      // A reload on the last row replaces the shift so columns abut.
      out_sr <= last_row ? col_ld : {8'h00, out_sr[3:1]};
      case (state)
        ST_IDLE:  state <= ST_FILL;
        ST_FILL:  if (last_row) state <= ST_STREAM;
        default:  state <= ST_STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_col_unit.sv
// Directed bench for inv_mix_col_unit: reset, known InvMixColumns vectors,
// back-to-back columns, running gaps, run abort, reset mid-stream and
// (when INV_MIX_COL_BYPASS_EN is defined) the bypass path.
module tb_inv_mix_col_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  inv_mix_col_unit_if #(.DATA_W(32)) bus ();

  inv_mix_col_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, compare out0 just after it.
  // Upper input bits carry garbage that must be ignored.
  task automatic cyc(input logic rs, input logic r, input logic rn,
                     input logic [7:0] a, input logic [7:0] k, input logic bp,
                     input logic [31:0] exp, input string tag);
    rst         = rs;
    bus.run     = r;
    bus.running = rn;
    bus.in0     = {24'hA5C3F0, a};
    bus.in1     = {24'h5A3C0F, k};
`ifdef INV_MIX_COL_BYPASS_EN
    bus.in2     = {31'h2AAA5555, bp};
`else
    if (bp) $display("note: bypass request ignored in this build");
`endif
    @(posedge clk);
    #1;
    chk(tag, bus.out0, exp);
  endtask

  task automatic run_pulse(input string tag);
    cyc(1'b0, 1'b1, 1'b1, 8'hEE, 8'h00, 1'b0, 32'h0, tag);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.running = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
`ifdef INV_MIX_COL_BYPASS_EN
    bus.in2 = '0;
`endif

    // Reset
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 32'h0, "rst0");
    cyc(1, 0, 1, 8'h12, 8'h00, 0, 32'h0, "rst1");

    // Vector 1: 8E,4D,A1,BC -> DB,13,53,45
    run_pulse("v1_run");
    cyc(0, 0, 1, 8'h8E, 8'h00, 0, 32'h00, "v1_r0");
    cyc(0, 0, 1, 8'h4D, 8'h00, 0, 32'h00, "v1_r1");
    cyc(0, 0, 1, 8'hA1, 8'h00, 0, 32'h00, "v1_r2");
    cyc(0, 0, 1, 8'hBC, 8'h00, 0, 32'hDB, "v1_b0");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h13, "v1_b1");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h53, "v1_b2");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h45, "v1_b3");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h00, "v1_z");

    // Vector 2: keyed column then back-to-back column
    run_pulse("v2_run");
    cyc(0, 0, 1, 8'h71, 8'hFF, 0, 32'h00, "v2_r0");
    cyc(0, 0, 1, 8'hB2, 8'hFF, 0, 32'h00, "v2_r1");
    cyc(0, 0, 1, 8'h5E, 8'hFF, 0, 32'h00, "v2_r2");
    cyc(0, 0, 1, 8'h43, 8'hFF, 0, 32'hDB, "v2_b0");
    cyc(0, 0, 1, 8'h9F, 8'h00, 0, 32'h13, "v2_b1");
    cyc(0, 0, 1, 8'hDC, 8'h00, 0, 32'h53, "v2_b2");
    cyc(0, 0, 1, 8'h58, 8'h00, 0, 32'h45, "v2_b3");
    cyc(0, 0, 1, 8'h9D, 8'h00, 0, 32'hF2, "v2_c0");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h0A, "v2_c1");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h22, "v2_c2");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h5C, "v2_c3");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h00, "v2_z");

    // Vector 3: 01 column with a 3-cycle gap after row 1, then a hold on output
    run_pulse("v3_run");
    cyc(0, 0, 1, 8'h01, 8'h00, 0, 32'h00, "v3_r0");
    cyc(0, 0, 1, 8'h01, 8'h00, 0, 32'h00, "v3_r1");
    cyc(0, 0, 0, 8'h77, 8'h00, 0, 32'h00, "v3_gap0");
    cyc(0, 0, 0, 8'h77, 8'h00, 0, 32'h00, "v3_gap1");
    cyc(0, 0, 0, 8'h77, 8'h00, 0, 32'h00, "v3_gap2");
    cyc(0, 0, 1, 8'h01, 8'h00, 0, 32'h00, "v3_r2");
    cyc(0, 0, 1, 8'h01, 8'h00, 0, 32'h01, "v3_b0");
    cyc(0, 0, 0, 8'h55, 8'h00, 0, 32'h01, "v3_hold0");
    cyc(0, 0, 0, 8'h55, 8'h00, 0, 32'h01, "v3_hold1");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h01, "v3_b1");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h01, "v3_b2");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h01, "v3_b3");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h00, "v3_z");

    // Vector 4: run aborts a partial column; byte in the run cycle is dropped
    run_pulse("v4_run");
    cyc(0, 0, 1, 8'h11, 8'h00, 0, 32'h00, "v4_p0");
    cyc(0, 0, 1, 8'h22, 8'h00, 0, 32'h00, "v4_p1");
    cyc(0, 1, 1, 8'h33, 8'h00, 0, 32'h00, "v4_abort");
    cyc(0, 0, 1, 8'h8E, 8'h00, 0, 32'h00, "v4_r0");
    cyc(0, 0, 1, 8'h4D, 8'h00, 0, 32'h00, "v4_r1");
    cyc(0, 0, 1, 8'hA1, 8'h00, 0, 32'h00, "v4_r2");
    cyc(0, 0, 1, 8'hBC, 8'h00, 0, 32'hDB, "v4_b0");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h13, "v4_b1");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h53, "v4_b2");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h45, "v4_b3");

    // Vector 5: rst with run and running mid-stream
    run_pulse("v5_run");
    cyc(0, 0, 1, 8'h8E, 8'h00, 0, 32'h00, "v5_r0");
    cyc(0, 0, 1, 8'h4D, 8'h00, 0, 32'h00, "v5_r1");
    cyc(0, 0, 1, 8'hA1, 8'h00, 0, 32'h00, "v5_r2");
    cyc(0, 0, 1, 8'hBC, 8'h00, 0, 32'hDB, "v5_b0");
    cyc(1, 1, 1, 8'h4D, 8'h00, 0, 32'h00, "v5_rst");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h00, "v5_post0");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h00, "v5_post1");

`ifdef INV_MIX_COL_BYPASS_EN
    // Vector 6: bypassed column, then a mixed column
    run_pulse("v6_run");
    cyc(0, 0, 1, 8'h8E, 8'h00, 1, 32'h00, "v6_r0");
    cyc(0, 0, 1, 8'h4D, 8'h00, 0, 32'h00, "v6_r1");
    cyc(0, 0, 1, 8'hA1, 8'h00, 0, 32'h00, "v6_r2");
    cyc(0, 0, 1, 8'hBC, 8'h00, 0, 32'h8E, "v6_b0");
    cyc(0, 0, 1, 8'h8E, 8'h00, 0, 32'h4D, "v6_b1");
    cyc(0, 0, 1, 8'h4D, 8'h00, 1, 32'hA1, "v6_b2");
    cyc(0, 0, 1, 8'hA1, 8'h00, 1, 32'hBC, "v6_b3");
    cyc(0, 0, 1, 8'hBC, 8'h00, 1, 32'hDB, "v6_m0");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h13, "v6_m1");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h53, "v6_m2");
    cyc(0, 0, 1, 8'h00, 8'h00, 0, 32'h45, "v6_m3");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
